// File: rtl/add_mul_seq_if.sv
// Operand/result handshake bundle for the sequential add-multiplier.
// The master side supplies operands and consumes results.
interface add_mul_seq_if #(
   parameter int widthX = 8,
   parameter int widthY = 8
);
   localparam int widthZ = widthX + widthY;
   localparam int widthP = widthX + widthY + 2;

   logic              in_valid;
   logic              in_ready;
   logic              tc;
   logic [widthX-1:0] xs;
   logic [widthX-1:0] xc;
   logic [widthY-1:0] y;
   logic [widthZ-1:0] z;
   logic              out_valid;
   logic              out_ready;
   logic [widthP-1:0] p;

   modport master (
      output in_valid, tc, xs, xc, y, z, out_ready,
      input  in_ready, out_valid, p
   );

   modport slave (
      input  in_valid, tc, xs, xc, y, z, out_ready,
      output in_ready, out_valid, p
   );
endinterface

// File: rtl/add_mul_seq.sv
// Iterative P = (XS + XC) * Y + Z, consuming DIGITS carry-save multiplier
// bits per cycle, in unsigned or two's-complement mode.
module add_mul_seq #(
   parameter int widthX = 8,
   parameter int widthY = 8,
   parameter int DIGITS = 1
) (
   input logic          clk,
   input logic          rstn,
   input logic          clr,
   add_mul_seq_if.slave bus
);
   localparam int widthZ = widthX + widthY;
   localparam int widthP = widthX + widthY + 2;
   localparam int N      = widthX / DIGITS;
   localparam int cntW   = (N > 1) ? $clog2(N) : 1;

   generate
      if (widthX % DIGITS != 0) begin : gen_digitsCheck
         $error("add_mul_seq: DIGITS must divide widthX");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   state_t            stateNext;
   logic [widthX-1:0] xsReg;
   logic [widthX-1:0] xcReg;
   logic [widthP-1:0] yReg;
   logic [widthP-1:0] acc;
   logic [widthP-1:0] accNext;
   logic [widthP-1:0] pReg;
   logic [widthP-1:0] term;
   logic              tcReg;
   logic [cntW-1:0]   cnt;
   logic              lastIter;
   logic              accept;
   logic              m1;
   logic              m2;

   assign lastIter = (cnt == cntW'(N - 1));
   assign accept   = bus.in_valid & bus.in_ready & ~clr;
   assign bus.p    = pReg;

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept) stateNext = BUSY;
         BUSY:    if (lastIter) stateNext = DONE;
         DONE:    if (bus.out_ready) stateNext = accept ? BUSY : IDLE;
         default: stateNext = IDLE;
      endcase
      if (clr) stateNext = IDLE;
   end

   // Ready is held low during reset; in DONE it follows the consumer so a
   // new operand set can be taken in the same cycle the result is drained.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      if (rstn) begin
         case (state)
            IDLE: bus.in_ready = 1'b1;
            DONE: begin
               bus.out_valid = 1'b1;
               bus.in_ready  = bus.out_ready;
            end
            default: ;
         endcase
      end
   end

   // The top multiplier bit carries negative weight in TC mode, so its
   // partial product is subtracted on the final slice.
   always_comb begin
      accNext = acc;
      m1      = 1'b0;
      m2      = 1'b0;
      term    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         m1   = xsReg[i] ^ xcReg[i];
         m2   = xsReg[i] & xcReg[i];
         term = (m1 ? (yReg << i) : '0) + (m2 ? (yReg << (i + 1)) : '0);
         if (tcReg && lastIter && (i == DIGITS - 1)) accNext = accNext - term;
         else                                        accNext = accNext + term;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         xsReg <= '0;
         xcReg <= '0;
         yReg  <= '0;
         acc   <= '0;
         pReg  <= '0;
         tcReg <= 1'b0;
         cnt   <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (accept) begin
         xsReg <= bus.xs;
         xcReg <= bus.xc;
         tcReg <= bus.tc;
         yReg  <= {{(widthX + 2){bus.tc & bus.y[widthY-1]}}, bus.y};
         acc   <= {{2{bus.tc & bus.z[widthZ-1]}}, bus.z};
         cnt   <= '0;
      end else if (state == BUSY) begin
         acc   <= accNext;
         xsReg <= xsReg >> DIGITS;
         xcReg <= xcReg >> DIGITS;
         yReg  <= yReg << DIGITS;
         cnt   <= cnt + 1'b1;
         if (lastIter) pReg <= accNext;
      end
   end
endmodule
